fifo_serial_tx: RTL and testbench

Read-side consumer for the byte FIFO: drains 8-bit entries through the FIFO's read port (`rd_en` / `empty` / `buf_out`) and serialises each byte onto a single asynchronous serial line. The line uses 1 start bit, 8 data bits LSB-first, an optional even-parity bit, and 1 stop bit. It sits in the FIFO's read clock domain and is the only agent that pulses the FIFO's `rd_en`.

---
 rtl/fifo_serial_tx.sv | 156 +++++++++++++++
 tb/tb_fifo_serial_tx.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_serial_tx.sv
// Drains bytes from the FIFO read port and sends them as 8N1 frames (start, 8 data LSB-first, stop).
// Define PARITY_EN to add an even-parity bit after the data, giving 11-bit frames.
module fifo_serial_tx #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk_r,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       empty,
  input  logic [7:0] buf_out,
  output logic       rd_en,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP,
    S_LOAD,
    S_START,
    S_DATA,
`ifdef PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          rd_en_d, tx_d, busy_d, tx_done_d;
  logic          bit_end, start_ok;
`ifdef PARITY_EN
  logic          par_q, par_d;
`endif

  assign bit_end  = (baud_q == BAUD_LAST);
  assign start_ok = enable && !empty;

  // State register and registered outputs
  always_ff @(posedge clk_r or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      rd_en   <= 1'b0;
      tx      <= 1'b1;
      busy    <= 1'b0;
      tx_done <= 1'b0;
`ifdef PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      rd_en   <= rd_en_d;
      tx      <= tx_d;
      busy    <= busy_d;
      tx_done <= tx_done_d;
`ifdef PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Next state, then outputs decoded from the next state so they register in step with it
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + CW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
`ifdef PARITY_EN
    par_d   = par_q;
`endif

    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        if (start_ok) state_d = S_POP;
      end
      S_POP: begin
        baud_d  = '0;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        baud_d  = '0;
        shift_d = buf_out;
`ifdef PARITY_EN
        par_d   = ^buf_out;
`endif
        state_d = S_START;
      end
      S_START: begin
        if (bit_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          baud_d  = '0;
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          baud_d  = '0;
          state_d = start_ok ? S_POP : S_IDLE;
        end
      end
      default: begin
        baud_d  = '0;
        state_d = S_IDLE;
      end
    endcase

    rd_en_d   = (state_d == S_POP);
    busy_d    = (state_d != S_IDLE);
    tx_done_d = (state_d == S_STOP) && (baud_d == BAUD_LAST);
    tx_d      = 1'b1;
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
`ifdef PARITY_EN
      S_PARITY: tx_d = par_d;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_fifo_serial_tx.sv
// Bench for fifo_serial_tx: a FIFO stand-in feeds bytes, a frame-offset model predicts every output each cycle.
// Build with PARITY_EN defined to exercise the parity variant.
module tb_fifo_serial_tx;

  localparam int CPB = 4;
`ifdef PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  // Frame offsets: 0 = POP, 1 = LOAD, 2.. = serial bits; last offset is the final STOP cycle
  localparam int FLAST = 2 + NB * CPB - 1;

  logic       clk_r = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       empty = 1'b1;
  logic [7:0] buf_out = 8'h00;
  logic       rd_en, tx, busy, tx_done;

  fifo_serial_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk_r   (clk_r),
    .rst_n   (rst_n),
    .enable  (enable),
    .empty   (empty),
    .buf_out (buf_out),
    .rd_en   (rd_en),
    .tx      (tx),
    .busy    (busy),
    .tx_done (tx_done)
  );

  always #5 clk_r = ~clk_r;

  int errors = 0;
  int checks = 0;
  int rd_cnt = 0;

  logic [7:0] fifo_q[$];
  logic [7:0] mdl_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", name, $time, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
    mdl_q.push_back(b);
  endtask

  // FIFO stand-in: pops during the rd_en cycle, so buf_out is valid by the following cycle
  always @(posedge clk_r) begin
    #1;
    if (rd_en === 1'b1) begin
      if (fifo_q.size() > 0) buf_out = fifo_q.pop_front();
      else buf_out = 8'h00;
    end
    empty = (fifo_q.size() == 0);
  end

  // Model: a frame is POP, LOAD, then NB serial bits of CPB cycles; decide on enable/empty when free
  logic       m_act;
  int         m_off;
  logic [7:0] m_byte;

  always @(posedge clk_r or negedge rst_n) begin
    if (!rst_n) begin
      m_act <= 1'b0;
      m_off <= 0;
    end else if (m_act && m_off != FLAST) begin
      m_off <= m_off + 1;
    end else if (enable && !empty) begin
      m_act  <= 1'b1;
      m_off  <= 0;
      m_byte <= (mdl_q.size() > 0) ? mdl_q.pop_front() : 8'h00;
    end else begin
      m_act <= 1'b0;
    end
  end

  always @(negedge clk_r) begin
    logic etx;
    int   k;
    etx = 1'b1;
    k   = 0;
    if (m_act && m_off >= 2) begin
      k = (m_off - 2) / CPB;
      if (k == 0) etx = 1'b0;
      else if (k <= 8) etx = m_byte[k-1];
`ifdef PARITY_EN
      else if (k == 9) etx = ^m_byte;
`endif
    end
    check("tx", 32'(tx), 32'(etx));
    check("rd_en", 32'(rd_en), 32'(m_act && m_off == 0));
    check("busy", 32'(busy), 32'(m_act));
    check("tx_done", 32'(tx_done), 32'(m_act && m_off == FLAST));
    if (rd_en === 1'b1) rd_cnt++;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_r);
    #1;
  endtask

  task automatic wait_start(output bit found);
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_r);
      if (tx === 1'b0) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL start_timeout t=%0t got=no_start exp=start_bit", $time);
    end
  endtask

  // Samples each bit slot mid-bit; returns the offset of tx_done from the first start-bit cycle
  task automatic capture(output logic [10:0] bits, output int done_off);
    bit found;
    int c;
    bits     = '0;
    done_off = -1;
    wait_start(found);
    if (found) begin
      c = 0;
      while (c < 300) begin
        if ((c % CPB) == 2 && (c / CPB) < NB) bits[c/CPB] = tx;
        if (tx_done === 1'b1) begin
          done_off = c;
          break;
        end
        @(negedge clk_r);
        c++;
      end
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_r);
      if (busy === 1'b0) break;
    end
    check("idle_reached", 32'(busy), 32'd0);
  endtask

  task automatic check_frame(input string name, input logic [10:0] bits,
                             input logic [7:0] b, input logic p);
    logic [10:0] e;
    e = {1'b0, 1'b1, b, 1'b0};
`ifdef PARITY_EN
    e = {1'b1, p, b, 1'b0};
`endif
    check(name, 32'(bits), 32'(e));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog t=%0t got=running exp=finished", $time);
    $fatal(1);
  end

  initial begin
    logic [10:0] bits;
    int          doff;
    int          r0;
    int          g;
    int          bad;
    bit          found;

    rst_n  = 1'b0;
    enable = 1'b1;
    push(8'hA5);
    cyc(3);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_rd_en", 32'(rd_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_tx_done", 32'(tx_done), 32'd0);
    rst_n = 1'b1;
    cyc(1);
    check("first_pop", 32'(rd_en), 32'd1);

    // Single byte 0xA5
    capture(bits, doff);
    check_frame("frame_a5", bits, 8'hA5, 1'b0);
    check("a5_done_off", 32'(doff), 32'(NB * CPB - 1));
    check("a5_pops", 32'(rd_cnt), 32'd1);
    wait_idle();

    // Back-to-back 0x01, 0xFF with a 2-cycle idle gap
    r0 = rd_cnt;
    push(8'h01);
    push(8'hFF);
    capture(bits, doff);
    check_frame("frame_01", bits, 8'h01, 1'b1);
    g = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_r);
      if (tx === 1'b0) break;
      g++;
    end
    check("b2b_gap", 32'(g), 32'd2);
    wait_idle();
    check("b2b_pops", 32'(rd_cnt - r0), 32'd2);

    // Empty FIFO with enable high: no pops, line stays high
    r0  = rd_cnt;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      cyc(1);
      if (tx !== 1'b1) bad++;
    end
    check("empty_tx_low", 32'(bad), 32'd0);
    check("empty_pops", 32'(rd_cnt - r0), 32'd0);

    // Enable dropped mid-frame with three bytes queued
    r0 = rd_cnt;
    push(8'h3C);
    push(8'h5A);
    push(8'h96);
    wait_start(found);
    cyc(2 * CPB);
    enable = 1'b0;
    wait_idle();
    check("drop_pops", 32'(rd_cnt - r0), 32'd1);
    check("drop_fifo_left", 32'(fifo_q.size()), 32'd2);
    cyc(20);
    check("drop_no_more_pops", 32'(rd_cnt - r0), 32'd1);

    // Asynchronous reset during data bit 3 of 0x5A
    enable = 1'b1;
    wait_start(found);
    cyc(4 * CPB + 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_tx", 32'(tx), 32'd1);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_rd_en", 32'(rd_en), 32'd0);
    r0 = rd_cnt;
    cyc(3);
    rst_n = 1'b1;
    capture(bits, doff);
    check_frame("frame_96_after_rst", bits, 8'h96, 1'b0);
    check("rst_new_pop", 32'(rd_cnt - r0), 32'd1);
    wait_idle();

    // Parity pair: 0x03 -> 0, 0x07 -> 1
    push(8'h03);
    push(8'h07);
    capture(bits, doff);
    check_frame("frame_03", bits, 8'h03, 1'b0);
    check("f03_done_off", 32'(doff), 32'(NB * CPB - 1));
    capture(bits, doff);
    check_frame("frame_07", bits, 8'h07, 1'b1);
    wait_idle();
    cyc(5);
    check("final_busy", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
